// File: rtl/bell_round_ctrl.sv
// bell_round_ctrl: round controller for a bell-slap card game.
// Arbitrates bell presses, judges the table and keeps saturating per-player scores.
module bell_round_ctrl #(
   parameter int NUM_PLAYERS = 2,
   parameter int SCORE_W     = 8,
   parameter int TARGET_SUM  = 5,
   parameter int PENALTY     = 1,
   parameter int WIN_SCORE   = 30
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [NUM_PLAYERS-1:0]         bell,
   input  logic                           card_valid,
   input  logic [2*NUM_PLAYERS-1:0]       card_color,
   input  logic [3*NUM_PLAYERS-1:0]       card_num,
   input  logic [7:0]                     pot,
   output logic [NUM_PLAYERS*SCORE_W-1:0] score,
   output logic                           round_done,
   output logic [2:0]                     presser,
   output logic                           ring_ok,
   output logic                           game_over,
   output logic [2:0]                     state
);
   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ARMED   = 3'd1,
      ST_JUDGE   = 3'd2,
      ST_AWARD   = 3'd3,
      ST_LOCKOUT = 3'd4,
      ST_OVER    = 3'd5
   } state_t;

   localparam longint SCORE_MAX = (64'sd1 <<< (SCORE_W - 1)) - 64'sd1;
   localparam longint SCORE_MIN = -SCORE_MAX - 64'sd1;
   localparam longint LOSS      = longint'(PENALTY) * longint'(NUM_PLAYERS - 1);

   state_t                    state_r;
   logic [2*NUM_PLAYERS-1:0]  color_r;
   logic [3*NUM_PLAYERS-1:0]  num_r;
   logic [7:0]                pot_r;
   logic [NUM_PLAYERS-1:0]    bell_prev_r;
   logic [2:0]                ptr_r;
   logic [2:0]                presser_r;
   logic                      ring_ok_r;
   logic                      round_done_r;
   logic                      game_over_r;
   logic signed [SCORE_W-1:0] score_r [NUM_PLAYERS];

   logic [NUM_PLAYERS-1:0]    press_s;
   logic [2*NUM_PLAYERS-1:0]  press_rot_s;
   logic                      any_press_s;
   logic [2:0]                winner_s;
   logic [2:0]                next_ptr_s;
   logic                      ring_s;
   logic                      win_s;
   logic signed [SCORE_W-1:0] new_score_s [NUM_PLAYERS];

   function automatic logic signed [SCORE_W-1:0] sat(input longint v);
      logic signed [SCORE_W-1:0] r;
      if (v > SCORE_MAX) begin
         r = SCORE_W'(SCORE_MAX);
      end else if (v < SCORE_MIN) begin
         r = SCORE_W'(SCORE_MIN);
      end else begin
         r = SCORE_W'(v);
      end
      return r;
   endfunction

   // Round-robin pick among rising bell edges, lowest offset from the pointer wins.
   always_comb begin
      press_s     = bell & ~bell_prev_r;
      any_press_s = |press_s;
      press_rot_s = {press_s, press_s} >> ptr_r;
      winner_s    = ptr_r;
      for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
         if (press_rot_s[i]) begin
            if (int'(ptr_r) + i >= NUM_PLAYERS) begin
               winner_s = 3'(int'(ptr_r) + i - NUM_PLAYERS);
            end else begin
               winner_s = 3'(int'(ptr_r) + i);
            end
         end else begin
            winner_s = winner_s;
         end
      end
      if (int'(winner_s) >= NUM_PLAYERS - 1) begin
         next_ptr_s = 3'd0;
      end else begin
         next_ptr_s = winner_s + 3'd1;
      end
   end

   // Table judgement: some colour's card numbers must add up to the target.
   always_comb begin
      logic [5:0] sum_v;
      ring_s = 1'b0;
      sum_v  = 6'd0;
      for (int c = 0; c < 4; c++) begin
         sum_v = 6'd0;
         for (int p = 0; p < NUM_PLAYERS; p++) begin
            if (color_r[2*p +: 2] == 2'(c)) begin
               sum_v = sum_v + {3'd0, num_r[3*p +: 3]};
            end else begin
               sum_v = sum_v;
            end
         end
         if (int'(sum_v) == TARGET_SUM) begin
            ring_s = 1'b1;
         end else begin
            ring_s = ring_s;
         end
      end
   end

   // Saturated award for the judged press, and the end-of-game test on current scores.
   always_comb begin
      longint v;
      win_s = 1'b0;
      v     = 64'sd0;
      for (int p = 0; p < NUM_PLAYERS; p++) begin
         v = longint'(score_r[p]);
         if (ring_ok_r) begin
            if (int'(presser_r) == p) begin
               v = v + longint'(pot_r);
            end else begin
               v = v;
            end
         end else begin
            if (int'(presser_r) == p) begin
               v = v - LOSS;
            end else begin
               v = v + longint'(PENALTY);
            end
         end
         new_score_s[p] = sat(v);
         if (longint'(score_r[p]) >= longint'(WIN_SCORE)) begin
            win_s = 1'b1;
         end else begin
            win_s = win_s;
         end
      end
   end

   // Game sequencer: latches cards, registers the judged press and applies the award.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_r      <= ST_IDLE;
         color_r      <= '0;
         num_r        <= '0;
         pot_r        <= 8'd0;
         bell_prev_r  <= '0;
         ptr_r        <= 3'd0;
         presser_r    <= 3'd0;
         ring_ok_r    <= 1'b0;
         round_done_r <= 1'b0;
         game_over_r  <= 1'b0;
         for (int p = 0; p < NUM_PLAYERS; p++) begin
            score_r[p] <= '0;
         end
      end else begin
         // A bell held through reset edges in IDLE, where presses are ignored.
         bell_prev_r  <= bell;
         round_done_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (card_valid) begin
                  color_r <= card_color;
                  num_r   <= card_num;
                  pot_r   <= pot;
                  state_r <= ST_ARMED;
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_ARMED: begin
               if (any_press_s) begin
                  presser_r <= winner_s;
                  ring_ok_r <= ring_s;
                  ptr_r     <= next_ptr_s;
                  state_r   <= ST_JUDGE;
               end else if (card_valid) begin
                  color_r <= card_color;
                  num_r   <= card_num;
                  pot_r   <= pot;
                  state_r <= ST_ARMED;
               end else begin
                  state_r <= ST_ARMED;
               end
            end
            ST_JUDGE: begin
               for (int p = 0; p < NUM_PLAYERS; p++) begin
                  score_r[p] <= new_score_s[p];
               end
               round_done_r <= 1'b1;
               state_r      <= ST_AWARD;
            end
            ST_AWARD: begin
               if (win_s) begin
                  game_over_r <= 1'b1;
                  state_r     <= ST_OVER;
               end else begin
                  state_r <= ST_LOCKOUT;
               end
            end
            ST_LOCKOUT: begin
               if (bell == '0) begin
                  state_r <= ST_IDLE;
               end else begin
                  state_r <= ST_LOCKOUT;
               end
            end
            ST_OVER: begin
               state_r <= ST_OVER;
            end
            default: begin
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_score
      assign score[g*SCORE_W +: SCORE_W] = score_r[g];
   end

   assign round_done = round_done_r;
   assign presser    = presser_r;
   assign ring_ok    = ring_ok_r;
   assign game_over  = game_over_r;
   assign state      = state_r;

endmodule

// File: tb/tb_bell_round_ctrl.sv
// tb_bell_round_ctrl: directed rounds on a 2-player and a 4-player controller,
// checked each cycle against a round-level scoring model plus literal expectations.
module tb_bell_round_ctrl;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   // DUT A: two players, default parameters
   logic        rst_a, cv_a, done_a, ok_a, go_a;
   logic [1:0]  bell_a;
   logic [3:0]  col_a;
   logic [5:0]  num_a;
   logic [7:0]  pot_a;
   logic [15:0] score_a;
   logic [2:0]  pr_a, st_a;

   // DUT B: four players, game ends at 127
   logic        rst_b, cv_b, done_b, ok_b, go_b;
   logic [3:0]  bell_b;
   logic [7:0]  col_b;
   logic [11:0] num_b;
   logic [7:0]  pot_b;
   logic [31:0] score_b;
   logic [2:0]  pr_b, st_b;

   bell_round_ctrl u_a (
      .clk(clk), .rst(rst_a), .bell(bell_a), .card_valid(cv_a), .card_color(col_a),
      .card_num(num_a), .pot(pot_a), .score(score_a), .round_done(done_a),
      .presser(pr_a), .ring_ok(ok_a), .game_over(go_a), .state(st_a));

   bell_round_ctrl #(.NUM_PLAYERS(4), .SCORE_W(8), .TARGET_SUM(5), .PENALTY(1), .WIN_SCORE(127)) u_b (
      .clk(clk), .rst(rst_b), .bell(bell_b), .card_valid(cv_b), .card_color(col_b),
      .card_num(num_b), .pot(pot_b), .score(score_b), .round_done(done_b),
      .presser(pr_b), .ring_ok(ok_b), .game_over(go_b), .state(st_b));

   int errors;
   int checks;
   int exp_s [2][8];
   bit exp_go [2];
   int ptr_m [2];
   bit chk_en;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic int np(input int w);
      return (w == 0) ? 2 : 4;
   endfunction

   function automatic int win_of(input int w);
      return (w == 0) ? 30 : 127;
   endfunction

   // f: 0 state, 1 presser, 2 ring_ok, 3 round_done, 4 game_over
   function automatic int rd(input int w, input int f);
      int v;
      case (f)
         0:       v = (w == 0) ? int'(st_a)   : int'(st_b);
         1:       v = (w == 0) ? int'(pr_a)   : int'(pr_b);
         2:       v = (w == 0) ? int'(ok_a)   : int'(ok_b);
         3:       v = (w == 0) ? int'(done_a) : int'(done_b);
         default: v = (w == 0) ? int'(go_a)   : int'(go_b);
      endcase
      return v;
   endfunction

   function automatic int rd_score(input int w, input int p);
      logic signed [7:0] b;
      if (w == 0) b = score_a[p*8 +: 8];
      else        b = score_b[p*8 +: 8];
      return int'(b);
   endfunction

   function automatic int sat8(input int v);
      if (v > 127)  return 127;
      if (v < -128) return -128;
      return v;
   endfunction

   function automatic bit model_ring(input int n, input logic [15:0] col, input logic [23:0] num);
      int s;
      for (int c = 0; c < 4; c++) begin
         s = 0;
         for (int p = 0; p < n; p++)
            if (int'(col[2*p +: 2]) == c) s += int'(num[3*p +: 3]);
         if (s == 5) return 1'b1;
      end
      return 1'b0;
   endfunction

   function automatic int model_winner(input int n, input int ptr, input logic [7:0] m);
      for (int i = 0; i < n; i++)
         if (m[(ptr + i) % n]) return (ptr + i) % n;
      return -1;
   endfunction

   task automatic model_award(input int w, input int who, input bit ok, input int pt, output bit over);
      over = 1'b0;
      for (int p = 0; p < np(w); p++) begin
         if (ok)            exp_s[w][p] = (p == who) ? sat8(exp_s[w][p] + pt) : exp_s[w][p];
         else if (p == who) exp_s[w][p] = sat8(exp_s[w][p] - (np(w) - 1));
         else               exp_s[w][p] = sat8(exp_s[w][p] + 1);
         if (exp_s[w][p] >= win_of(w)) over = 1'b1;
      end
   endtask

   task automatic cmp_all();
      for (int p = 0; p < 2; p++) check("score_a", rd_score(0, p), exp_s[0][p]);
      for (int p = 0; p < 4; p++) check("score_b", rd_score(1, p), exp_s[1][p]);
      check("game_over_a", rd(0, 4), int'(exp_go[0]));
      check("game_over_b", rd(1, 4), int'(exp_go[1]));
   endtask

   // One clock: compare the model for the cycle just observed, then advance.
   task automatic step();
      if (chk_en) cmp_all();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int w, input logic [7:0] bl, input logic cv,
                        input logic [15:0] col, input logic [23:0] num, input logic [7:0] pt);
      if (w == 0) begin
         bell_a = bl[1:0]; cv_a = cv; col_a = col[3:0]; num_a = num[5:0]; pot_a = pt;
      end else begin
         bell_b = bl[3:0]; cv_b = cv; col_b = col[7:0]; num_b = num[11:0]; pot_b = pt;
      end
   endtask

   task automatic play(input int w, input logic [15:0] col, input logic [23:0] num, input int pt,
                       input logic [7:0] press, input bit hold, input int lit_pr);
      int who;
      bit ok;
      bit over;
      string tag;
      tag = (w == 0) ? "a_" : "b_";
      drive(w, 8'd0, 1'b1, col, num, 8'(pt));
      step();
      drive(w, 8'd0, 1'b0, col, num, 8'(pt));
      check({tag, "armed"}, rd(w, 0), 1);
      drive(w, press, 1'b0, col, num, 8'(pt));
      step();
      who = model_winner(np(w), ptr_m[w], press);
      ok = model_ring(np(w), col, num);
      ptr_m[w] = (who + 1) % np(w);
      check({tag, "judge_state"}, rd(w, 0), 2);
      check({tag, "presser"}, rd(w, 1), who);
      if (lit_pr >= 0) check({tag, "presser_literal"}, rd(w, 1), lit_pr);
      check({tag, "ring_ok"}, rd(w, 2), int'(ok));
      check({tag, "done_in_judge"}, rd(w, 3), 0);
      step();
      model_award(w, who, ok, pt, over);
      check({tag, "award_state"}, rd(w, 0), 3);
      check({tag, "round_done"}, rd(w, 3), 1);
      step();
      exp_go[w] = over;
      check({tag, "post_award_state"}, rd(w, 0), over ? 5 : 4);
      check({tag, "done_one_cycle"}, rd(w, 3), 0);
      if (hold) begin
         drive(w, press, 1'b1, col, num, 8'(pt));
         step();
         check({tag, "lockout_held"}, rd(w, 0), 4);
         drive(w, press, 1'b0, col, num, 8'(pt));
         step();
         check({tag, "lockout_held2"}, rd(w, 0), 4);
      end
      drive(w, 8'd0, 1'b0, col, num, 8'(pt));
      step();
      check({tag, "after_release"}, rd(w, 0), over ? 5 : 0);
   endtask

   localparam logic [15:0] COL_B = {8'd0, 2'd1, 2'd1, 2'd1, 2'd0};
   localparam logic [23:0] NUM_B = {12'd0, 3'd0, 3'd0, 3'd0, 3'd5};

   initial begin
      errors = 0;
      checks = 0;
      chk_en = 1'b0;
      rst_a  = 1'b0;
      rst_b  = 1'b0;
      drive(0, 8'd0, 1'b0, 16'd0, 24'd0, 8'd0);
      drive(1, 8'd0, 1'b0, 16'd0, 24'd0, 8'd0);
      for (int w = 0; w < 2; w++) begin
         for (int p = 0; p < 8; p++) exp_s[w][p] = 0;
         exp_go[w] = 1'b0;
         ptr_m[w]  = 0;
      end
      step();
      step();
      for (int w = 0; w < 2; w++)
         for (int f = 0; f < 5; f++) check("reset_outputs", rd(w, f), 0);
      rst_a  = 1'b1;
      rst_b  = 1'b1;
      chk_en = 1'b1;
      step();

      // P1 rings on a colour-0 pair adding to 5
      play(0, 16'd0, {18'd0, 3'd3, 3'd2}, 6, 8'b10, 1'b0, 1);
      check("a1_score1", rd_score(0, 1), 6);
      check("a1_score0", rd_score(0, 0), 0);
      // single card of 5 is correct; then a miss costs P0 one point
      play(0, {12'd0, 2'd1, 2'd0}, {18'd0, 3'd2, 3'd5}, 4, 8'b01, 1'b0, 0);
      check("a2_score0", rd_score(0, 0), 4);
      play(0, {12'd0, 2'd1, 2'd0}, {18'd0, 3'd2, 3'd2}, 3, 8'b01, 1'b0, 0);
      check("a3_score0", rd_score(0, 0), 3);
      check("a3_score1", rd_score(0, 1), 7);
      // bell held through lockout, with a card_valid that must be ignored
      play(0, {12'd0, 2'd2, 2'd0}, {18'd0, 3'd5, 3'd1}, 2, 8'b01, 1'b1, 0);
      check("a4_score0", rd_score(0, 0), 5);

      // reset while judging, with bell1 still held afterwards
      drive(0, 8'd0, 1'b1, 16'd0, 24'd0, 8'd0);
      step();
      drive(0, 8'b10, 1'b0, 16'd0, 24'd0, 8'd0);
      step();
      check("a5_judge_before_reset", rd(0, 0), 2);
      rst_a = 1'b0;
      step();
      exp_s[0][0] = 0;
      exp_s[0][1] = 0;
      ptr_m[0]    = 0;
      for (int f = 0; f < 5; f++) check("a5_reset_in_judge", rd(0, f), 0);
      rst_a = 1'b1;
      drive(0, 8'b10, 1'b1, 16'd0, 24'd0, 8'd0);
      step();
      drive(0, 8'b10, 1'b0, 16'd0, 24'd0, 8'd0);
      step();
      step();
      check("a5_held_bell_ignored", rd(0, 0), 1);
      drive(0, 8'd0, 1'b0, 16'd0, 24'd0, 8'd0);
      step();
      play(0, {12'd0, 2'd1, 2'd1}, {18'd0, 3'd4, 3'd1}, 9, 8'b10, 1'b0, 1);
      check("a5_score1", rd_score(0, 1), 9);

      // four simultaneous presses, twice: pointer rotates 0 then 1
      play(1, COL_B, NUM_B, 20, 8'h0F, 1'b0, 0);
      play(1, COL_B, NUM_B, 20, 8'h0F, 1'b0, 1);
      check("b2_score1", rd_score(1, 1), 20);
      // wrong press by P2 pays 3 in total
      play(1, 16'd0, {12'd0, 3'd1, 3'd1, 3'd1, 3'd1}, 7, 8'b0100, 1'b0, 2);
      check("b3_score2", rd_score(1, 2), -3);
      check("b3_score0", rd_score(1, 0), 21);
      play(1, COL_B, NUM_B, 105, 8'b0001, 1'b0, 0);
      check("b4_score0", rd_score(1, 0), 126);
      play(1, COL_B, NUM_B, 10, 8'b0001, 1'b0, 0);
      check("b5_score0_sat", rd_score(1, 0), 127);
      check("b5_game_over", rd(1, 4), 1);
      check("b5_state_over", rd(1, 0), 5);
      // everything ignored once over
      drive(1, 8'h0F, 1'b1, COL_B, NUM_B, 8'd50);
      step();
      drive(1, 8'h00, 1'b0, COL_B, NUM_B, 8'd50);
      step();
      drive(1, 8'h02, 1'b0, COL_B, NUM_B, 8'd50);
      step();
      step();
      check("b6_over_held", rd(1, 0), 5);
      check("b6_no_round_done", rd(1, 3), 0);
      check("b6_presser_frozen", rd(1, 1), 0);
      cmp_all();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
